// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing the single l1mmu line port between the L1 icache and dcache.
// A grant is held for a whole line transaction; a sticky watchdog flags transactions that never finish.
module l1_mem_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         ic_read,
  input  logic [31:0]  ic_addr,
  output logic         ic_done,
  output logic [255:0] ic_read_data,
  input  logic         dc_read,
  input  logic         dc_write,
  input  logic [31:0]  dc_addr,
  input  logic [255:0] dc_write_data,
  output logic         dc_done,
  output logic [255:0] dc_read_data,
  output logic         mmu_read,
  output logic         mmu_write,
  output logic [31:0]  mmu_addr,
  output logic [255:0] mmu_write_data,
  input  logic         mmu_done,
  input  logic [255:0] mmu_read_data,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t         state_reg, state_next;
  logic           last_grant_reg, last_grant_next;
  logic           mmu_read_reg, mmu_read_next;
  logic           mmu_write_reg, mmu_write_next;
  logic [31:0]    mmu_addr_reg, mmu_addr_next;
  logic [255:0]   mmu_write_data_reg, mmu_write_data_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic           timeout_err_reg, timeout_err_next;

  logic ic_req;
  logic dc_req;
  logic grant_i;
  logic grant_d;

  assign ic_req = ic_read;
  assign dc_req = dc_read | dc_write;
  // On a tie the port that did not win last time is served.
  assign grant_i = ic_req && (!dc_req || (last_grant_reg == GRANT_D));
  assign grant_d = dc_req && !grant_i;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      last_grant_reg     <= GRANT_D;
      mmu_read_reg       <= 1'b0;
      mmu_write_reg      <= 1'b0;
      mmu_addr_reg       <= '0;
      mmu_write_data_reg <= '0;
      cnt_reg            <= '0;
      timeout_err_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      last_grant_reg     <= last_grant_next;
      mmu_read_reg       <= mmu_read_next;
      mmu_write_reg      <= mmu_write_next;
      mmu_addr_reg       <= mmu_addr_next;
      mmu_write_data_reg <= mmu_write_data_next;
      cnt_reg            <= cnt_next;
      timeout_err_reg    <= timeout_err_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    last_grant_next     = last_grant_reg;
    mmu_read_next       = mmu_read_reg;
    mmu_write_next      = mmu_write_reg;
    mmu_addr_next       = mmu_addr_reg;
    mmu_write_data_next = mmu_write_data_reg;
    cnt_next            = cnt_reg;
    timeout_err_next    = timeout_err_reg;

    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          state_next      = BUSY_I;
          last_grant_next = GRANT_I;
          mmu_read_next   = 1'b1;
          mmu_write_next  = 1'b0;
          mmu_addr_next   = ic_addr;
          cnt_next        = '0;
        end else if (grant_d) begin
          state_next          = BUSY_D;
          last_grant_next     = GRANT_D;
          // A writeback takes priority over a read asserted alongside it.
          mmu_read_next       = !dc_write;
          mmu_write_next      = dc_write;
          mmu_addr_next       = dc_addr;
          mmu_write_data_next = dc_write_data;
          cnt_next            = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_reg != TIMEOUT_CNT) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (cnt_next == TIMEOUT_CNT) begin
          timeout_err_next = 1'b1;
        end
        if (mmu_done) begin
          mmu_read_next  = 1'b0;
          mmu_write_next = 1'b0;
          state_next     = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mmu_read       = mmu_read_reg;
  assign mmu_write      = mmu_write_reg;
  assign mmu_addr       = mmu_addr_reg;
  assign mmu_write_data = mmu_write_data_reg;
  assign timeout_err    = timeout_err_reg;

  // Completions are routed by owner; a stray mmu_done in IDLE or GAP goes nowhere.
  assign ic_done      = mmu_done && (state_reg == BUSY_I);
  assign dc_done      = mmu_done && (state_reg == BUSY_D);
  assign ic_read_data = mmu_read_data;
  assign dc_read_data = mmu_read_data;

endmodule
